// File: rtl/wb_dual_master_arbiter_if.sv
// Bus bundle for the dual-master Wishbone arbiter: instruction master, data master,
// shared slave port and arbiter status. The slave modport is the arbiter's view;
// the master modport is the surrounding environment's view.
interface wb_dual_master_arbiter_if;
    // Instruction-fetch master side
    logic [31:0] i_adr_i;
    logic        i_cyc_i;
    logic        i_stb_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o;
    logic        i_err_o;
    // Data master side
    logic [31:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic        d_cyc_i;
    logic        d_stb_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o;
    logic        d_err_o;
    // Shared slave side
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_err_i;
    // Status
    logic [1:0]  grant_o;
    logic        timeout_o;

    modport slave (
        input  i_adr_i, i_cyc_i, i_stb_i,
        output i_dat_o, i_ack_o, i_err_o,
        input  d_adr_i, d_dat_i, d_we_i, d_sel_i, d_cyc_i, d_stb_i,
        output d_dat_o, d_ack_o, d_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i,
        output grant_o, timeout_o
    );

    modport master (
        output i_adr_i, i_cyc_i, i_stb_i,
        input  i_dat_o, i_ack_o, i_err_o,
        output d_adr_i, d_dat_i, d_we_i, d_sel_i, d_cyc_i, d_stb_i,
        input  d_dat_o, d_ack_o, d_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Shares one Wishbone slave port between the instruction-fetch and data masters.
// Data has fixed priority, but after D_STREAK_MAX consecutive data grants taken
// while the instruction master waits, the instruction master is granted next.
// A per-transaction timeout ends a hung access with an error to the owner.
module wb_dual_master_arbiter #(
    parameter int unsigned D_STREAK_MAX   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                     clk,
    input logic                     rst,
    wb_dual_master_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGntI = 2'b01,
        StGntD = 2'b10
    } state_e;

    localparam logic [3:0] StreakMax = 4'(D_STREAK_MAX);
    localparam bit         TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TmoLast   = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [1:0]  grant_q;
    logic [3:0]  streak_q;
    logic [7:0]  tmo_cnt_q;

    logic        req_i, req_d;
    logic        own_i, own_d, own_cyc;
    logic        timeout_hit, done;

    logic [31:0] s_adr, s_dat;
    logic        s_we, s_cyc, s_stb;
    logic [3:0]  s_sel;
    logic        i_ack, i_err, d_ack, d_err;

    // Request decode, ownership and the timeout condition for the current cycle
    always_comb begin
        req_i   = bus.i_cyc_i & bus.i_stb_i;
        req_d   = bus.d_cyc_i & bus.d_stb_i;
        own_i   = (state_q == StGntI);
        own_d   = (state_q == StGntD);
        own_cyc = (own_i & bus.i_cyc_i) | (own_d & bus.d_cyc_i);
        // An owner abort or a real ack/err on the last cycle takes precedence over the timeout
        timeout_hit = TimeoutEn && own_cyc && (tmo_cnt_q == TmoLast) &&
                      !bus.s_ack_i && !bus.s_err_i;
    end

    // Slave-side mux selected by the current owner
    always_comb begin
        s_adr = 32'h0;
        s_dat = 32'h0;
        s_we  = 1'b0;
        s_sel = 4'h0;
        s_cyc = 1'b0;
        s_stb = 1'b0;
        unique case (state_q)
            StGntI: begin
                s_adr = bus.i_adr_i;
                s_sel = 4'hF;
                s_cyc = bus.i_cyc_i;
                s_stb = bus.i_stb_i;
            end
            StGntD: begin
                s_adr = bus.d_adr_i;
                s_dat = bus.d_dat_i;
                s_we  = bus.d_we_i;
                s_sel = bus.d_sel_i;
                s_cyc = bus.d_cyc_i;
                s_stb = bus.d_stb_i;
            end
            default: ;
        endcase
        if (timeout_hit) begin
            s_cyc = 1'b0;
            s_stb = 1'b0;
        end
    end

    // Return path: only the owner sees ack/err
    always_comb begin
        i_ack = bus.s_ack_i & own_i & s_stb;
        d_ack = bus.s_ack_i & own_d & s_stb;
        i_err = (bus.s_err_i & own_i & s_stb) | (timeout_hit & own_i);
        d_err = (bus.s_err_i & own_d & s_stb) | (timeout_hit & own_d);
        done  = i_ack | i_err | d_ack | d_err | ((own_i | own_d) & !own_cyc);
    end

    assign bus.s_adr_o   = s_adr;
    assign bus.s_dat_o   = s_dat;
    assign bus.s_we_o    = s_we;
    assign bus.s_sel_o   = s_sel;
    assign bus.s_cyc_o   = s_cyc;
    assign bus.s_stb_o   = s_stb;
    assign bus.i_dat_o   = bus.s_dat_i;
    assign bus.d_dat_o   = bus.s_dat_i;
    assign bus.i_ack_o   = i_ack;
    assign bus.i_err_o   = i_err;
    assign bus.d_ack_o   = d_ack;
    assign bus.d_err_o   = d_err;
    assign bus.grant_o   = grant_q;
    assign bus.timeout_o = timeout_hit;

    // Arbitration FSM with registered grant, streak and timeout counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            streak_q  <= 4'd0;
            tmo_cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tmo_cnt_q <= 8'd0;
                    if (req_d && (!req_i || streak_q != StreakMax)) begin
                        state_q <= StGntD;
                        grant_q <= 2'b10;
                        // Streak only counts data wins over a waiting fetch
                        if (req_i && streak_q != StreakMax) begin
                            streak_q <= streak_q + 4'd1;
                        end else if (!req_i) begin
                            streak_q <= 4'd0;
                        end
                    end else if (req_i) begin
                        state_q  <= StGntI;
                        grant_q  <= 2'b01;
                        streak_q <= 4'd0;
                    end else begin
                        streak_q <= 4'd0;
                    end
                end
                StGntI, StGntD: begin
                    if (done) begin
                        state_q   <= StIdle;
                        grant_q   <= 2'b00;
                        tmo_cnt_q <= 8'd0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule
